instruction_queue: RTL and testbench

- Parametrised successor to the single-word instruction register.
- Holds up to DEPTH fetched instruction words in FIFO order between fetch and decode, so fetch can run ahead of execution.
- Presents the head word first-word-fall-through, with its opcode and operand fields already split for the decoder.
- Adds a synchronous flush for branches and jumps, plus sticky overflow/underflow error flags.

---
 rtl/instruction_queue.sv | 99 +++++++++
 tb/tb_instruction_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// FIFO of fetched instruction words between fetch and decode, head presented
// first-word-fall-through and pre-split into opcode/operand, with flush and sticky error flags.
module instruction_queue #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int OPCODE_WIDTH      = 5,
  parameter int DEPTH             = 4
) (
  input  logic                                      clock,
  input  logic                                      iq_reset,
  input  logic [INSTRUCTION_WIDTH-1:0]              iq_in,
  input  logic                                      iq_wr,
  input  logic                                      iq_rd,
  input  logic                                      iq_flush,
  output logic [INSTRUCTION_WIDTH-1:0]              iq_out,
  output logic [OPCODE_WIDTH-1:0]                   iq_opcode,
  output logic [INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0] iq_operand,
  output logic [$clog2(DEPTH+1)-1:0]                iq_count,
  output logic                                      iq_empty,
  output logic                                      iq_full,
  output logic                                      iq_ovf,
  output logic                                      iq_udf
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [INSTRUCTION_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]                r_wrPtr;
  logic [PW-1:0]                r_rdPtr;
  logic [CW-1:0]                r_count;
  logic                         r_ovf;
  logic                         r_udf;

  logic          w_empty;
  logic          w_full;
  logic          w_popOk;
  logic          w_pushOk;
  logic [PW-1:0] w_wrPtrNext;
  logic [PW-1:0] w_rdPtrNext;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  // A pop frees the tail slot in the same edge, so a full queue can still accept a push.
  assign w_popOk  = iq_rd && !w_empty;
  assign w_pushOk = iq_wr && (!w_full || w_popOk);

  // DEPTH need not be a power of two, so wrap by explicit compare.
  assign w_wrPtrNext = (r_wrPtr == PW'(DEPTH-1)) ? '0 : r_wrPtr + PW'(1);
  assign w_rdPtrNext = (r_rdPtr == PW'(DEPTH-1)) ? '0 : r_rdPtr + PW'(1);

  always_ff @(posedge clock) begin
    if (!iq_flush && w_pushOk) begin
      r_mem[r_wrPtr] <= iq_in;
    end
  end

  always_ff @(posedge clock or posedge iq_reset) begin
    if (iq_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (iq_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= w_wrPtrNext;
      end
      if (w_popOk) begin
        r_rdPtr <= w_rdPtrNext;
      end
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (iq_wr && !w_pushOk) begin
        r_ovf <= 1'b1;
      end
      if (iq_rd && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  // Empty gating keeps never-written or already-popped storage off the outputs.
  assign iq_out     = w_empty ? '0 : r_mem[r_rdPtr];
  assign iq_opcode  = iq_out[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign iq_operand = iq_out[INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0];
  assign iq_count   = r_count;
  assign iq_empty   = w_empty;
  assign iq_full    = w_full;
  assign iq_ovf     = r_ovf;
  assign iq_udf     = r_udf;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue (DEPTH = 4, 16-bit words).
module tb_instruction_queue;

  logic        clock;
  logic        iq_reset;
  logic [15:0] iq_in;
  logic        iq_wr;
  logic        iq_rd;
  logic        iq_flush;
  logic [15:0] iq_out;
  logic [4:0]  iq_opcode;
  logic [10:0] iq_operand;
  logic [2:0]  iq_count;
  logic        iq_empty;
  logic        iq_full;
  logic        iq_ovf;
  logic        iq_udf;

  int checks = 0;
  int errors = 0;

  logic [15:0] fillWords [4];

  instruction_queue #(
    .INSTRUCTION_WIDTH(16),
    .OPCODE_WIDTH(5),
    .DEPTH(4)
  ) dut (
    .clock(clock),
    .iq_reset(iq_reset),
    .iq_in(iq_in),
    .iq_wr(iq_wr),
    .iq_rd(iq_rd),
    .iq_flush(iq_flush),
    .iq_out(iq_out),
    .iq_opcode(iq_opcode),
    .iq_operand(iq_operand),
    .iq_count(iq_count),
    .iq_empty(iq_empty),
    .iq_full(iq_full),
    .iq_ovf(iq_ovf),
    .iq_udf(iq_udf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    iq_wr = 1'b0; iq_rd = 1'b0; iq_flush = 1'b0;
  endtask

  task automatic push(input logic [15:0] w);
    iq_in = w; iq_wr = 1'b1; iq_rd = 1'b0; iq_flush = 1'b0;
    tick();
    idle();
  endtask

  task automatic test_reset();
    tick();
    #2;
    iq_reset = 1'b1;
    #1;
    checks++; if (iq_out !== 16'h0) begin errors++; $display("[TB] FAIL reset_out: got %h expected %h", iq_out, 16'h0); end
    checks++; if (iq_opcode !== 5'h0 || iq_operand !== 11'h0) begin errors++; $display("[TB] FAIL reset_fields: got %h/%h expected 0/0", iq_opcode, iq_operand); end
    checks++; if (iq_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", iq_count); end
    checks++; if (iq_empty !== 1'b1 || iq_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got empty=%b full=%b expected 1 0", iq_empty, iq_full); end
    checks++; if (iq_ovf !== 1'b0 || iq_udf !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got ovf=%b udf=%b expected 0 0", iq_ovf, iq_udf); end
    #2;
    iq_reset = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      push(fillWords[i]);
      checks++; if (iq_count !== 3'(i + 1)) begin errors++; $display("[TB] FAIL fill_count%0d: got %0d expected %0d", i, iq_count, i + 1); end
    end
    checks++; if (iq_full !== 1'b1 || iq_empty !== 1'b0) begin errors++; $display("[TB] FAIL fill_full: got full=%b empty=%b expected 1 0", iq_full, iq_empty); end
    checks++; if (iq_out !== 16'h2CB2) begin errors++; $display("[TB] FAIL fill_head: got %h expected 2cb2", iq_out); end
    checks++; if (iq_opcode !== 5'b00101) begin errors++; $display("[TB] FAIL fill_opcode: got %b expected 00101", iq_opcode); end
    checks++; if (iq_operand !== 11'h4B2) begin errors++; $display("[TB] FAIL fill_operand: got %h expected 4b2", iq_operand); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (iq_out !== fillWords[i]) begin errors++; $display("[TB] FAIL drain_word%0d: got %h expected %h", i, iq_out, fillWords[i]); end
      iq_rd = 1'b1;
      tick();
      idle();
    end
    checks++; if (iq_empty !== 1'b1 || iq_out !== 16'h0) begin errors++; $display("[TB] FAIL drain_empty: got empty=%b out=%h expected 1 0000", iq_empty, iq_out); end
  endtask

  task automatic test_flush_clean();
    push(16'h1111); push(16'h2222); push(16'h3333);
    iq_in = 16'h4444; iq_wr = 1'b1; iq_rd = 1'b1; iq_flush = 1'b1;
    tick();
    idle();
    checks++; if (iq_count !== 3'd0 || iq_empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_count: got count=%0d empty=%b expected 0 1", iq_count, iq_empty); end
    checks++; if (iq_out !== 16'h0) begin errors++; $display("[TB] FAIL flush_out: got %h expected 0000", iq_out); end
    iq_rd = 1'b1; iq_flush = 1'b1;
    tick();
    idle();
    checks++; if (iq_udf !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_udf: got %b expected 0", iq_udf); end
    for (int i = 0; i < 4; i++) push(fillWords[i]);
    iq_in = 16'h5555; iq_wr = 1'b1; iq_flush = 1'b1;
    tick();
    idle();
    checks++; if (iq_ovf !== 1'b0 || iq_count !== 3'd0) begin errors++; $display("[TB] FAIL flush_no_ovf: got ovf=%b count=%0d expected 0 0", iq_ovf, iq_count); end
  endtask

  task automatic test_overflow_wrap();
    for (int i = 0; i < 4; i++) push(fillWords[i]);
    push(16'hAAAA);
    checks++; if (iq_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", iq_ovf); end
    checks++; if (iq_count !== 3'd4 || iq_out !== 16'h2CB2) begin errors++; $display("[TB] FAIL ovf_hold: got count=%0d head=%h expected 4 2cb2", iq_count, iq_out); end
    iq_in = 16'hBBBB; iq_wr = 1'b1; iq_rd = 1'b1;
    tick();
    idle();
    checks++; if (iq_out !== 16'hF492 || iq_count !== 3'd4) begin errors++; $display("[TB] FAIL wrap_head: got head=%h count=%0d expected f492 4", iq_out, iq_count); end
    checks++; if (iq_full !== 1'b1) begin errors++; $display("[TB] FAIL wrap_full: got %b expected 1", iq_full); end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] exp;
      exp = (i == 3) ? 16'hBBBB : fillWords[i + 1];
      checks++; if (iq_out !== exp) begin errors++; $display("[TB] FAIL wrap_word%0d: got %h expected %h", i, iq_out, exp); end
      iq_rd = 1'b1;
      tick();
      idle();
    end
    checks++; if (iq_empty !== 1'b1 || iq_udf !== 1'b0) begin errors++; $display("[TB] FAIL wrap_end: got empty=%b udf=%b expected 1 0", iq_empty, iq_udf); end
  endtask

  task automatic test_underflow();
    iq_rd = 1'b1;
    tick();
    idle();
    checks++; if (iq_udf !== 1'b1 || iq_count !== 3'd0) begin errors++; $display("[TB] FAIL udf_flag: got udf=%b count=%0d expected 1 0", iq_udf, iq_count); end
    iq_in = 16'h1234; iq_wr = 1'b1; iq_rd = 1'b1;
    tick();
    idle();
    checks++; if (iq_count !== 3'd1 || iq_out !== 16'h1234) begin errors++; $display("[TB] FAIL udf_push: got count=%0d out=%h expected 1 1234", iq_count, iq_out); end
    iq_rd = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_flush_retains();
    push(16'h1111); push(16'h2222); push(16'h3333);
    iq_in = 16'h4444; iq_wr = 1'b1; iq_rd = 1'b1; iq_flush = 1'b1;
    tick();
    idle();
    checks++; if (iq_count !== 3'd0 || iq_empty !== 1'b1) begin errors++; $display("[TB] FAIL flush2_count: got count=%0d empty=%b expected 0 1", iq_count, iq_empty); end
    checks++; if (iq_ovf !== 1'b1 || iq_udf !== 1'b1) begin errors++; $display("[TB] FAIL flush2_keep: got ovf=%b udf=%b expected 1 1", iq_ovf, iq_udf); end
  endtask

  task automatic test_reset_midstream();
    push(16'h7777); push(16'h8888);
    #2;
    iq_reset = 1'b1;
    #1;
    checks++; if (iq_count !== 3'd0 || iq_empty !== 1'b1 || iq_out !== 16'h0) begin errors++; $display("[TB] FAIL mid_reset: got count=%0d empty=%b out=%h expected 0 1 0000", iq_count, iq_empty, iq_out); end
    checks++; if (iq_ovf !== 1'b0 || iq_udf !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_err: got ovf=%b udf=%b expected 0 0", iq_ovf, iq_udf); end
    #2;
    iq_reset = 1'b0;
    push(16'h0001);
    checks++; if (iq_out !== 16'h0001 || iq_count !== 3'd1) begin errors++; $display("[TB] FAIL mid_push: got out=%h count=%0d expected 0001 1", iq_out, iq_count); end
  endtask

  initial begin
    fillWords[0] = 16'h2CB2;
    fillWords[1] = 16'hF492;
    fillWords[2] = 16'h0613;
    fillWords[3] = 16'h110F;
    iq_reset = 1'b1;
    iq_in = 16'h0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    iq_reset = 1'b0;
    $display("[TB] starting directed tests");
    test_reset();
    test_fill_drain();
    test_flush_clean();
    test_overflow_wrap();
    test_underflow();
    test_flush_retains();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
